regfile_wb_arbiter: RTL and testbench

Write-back arbiter that owns the single synchronous write port of a `regfile`/`fpuregfile` instance. It merges two result sources:
- **A:** the in-order pipeline write-back, which has no stall input and always wins.
- **B:** a long-latency unit (FPU/multiplier) with a valid/ready handshake, buffered in a small FIFO.

The block drives `WriteData`/`WriteRegister`/`RegWrite` from registers. It also exports a pending-write mask for hazard detection and a stall request that prevents B results from starving.

---
 rtl/regfile_wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for a single regfile write port: in-order pipeline (A) always wins,
// long-latency results (B) are buffered in a small FIFO with kill-on-overwrite and an anti-starve stall.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned STARVE_LIMIT     = 8,
  parameter bit          ZERO_REG_DISCARD = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        AValid,
  input  logic [4:0]  AReg,
  input  logic [31:0] AData,
  input  logic        BValid,
  output logic        BReady,
  input  logic [4:0]  BReg,
  input  logic [31:0] BData,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteRegister,
  output logic        RegWrite,
  output logic [31:0] Pending,
  output logic        StallReq
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

  logic [DEPTH-1:0] valid_q, valid_d, kill_q, kill_d;
  logic [4:0]       reg_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [StW-1:0]   starve_q, starve_d;
  logic             out_is_b_q, out_is_b_d;
  logic             reg_write_d;
  logic [4:0]       write_reg_d;
  logic [31:0]      write_data_d;

  logic a_win, accept, push, pop, b_load;
  logic head_valid, head_kill, head_live;

  assign BReady     = ~(&valid_q);
  assign a_win      = AValid & ~(ZERO_REG_DISCARD && (AReg == 5'd0));
  assign accept     = BValid & BReady;
  assign push       = accept & ~(ZERO_REG_DISCARD && (BReg == 5'd0));
  assign head_valid = valid_q[rd_ptr_q];
  assign head_kill  = kill_q[rd_ptr_q];
  assign head_live  = head_valid & ~head_kill;
  assign b_load     = head_live & ~a_win;
  // Killed heads drain even while A owns the port.
  assign pop        = head_valid & (head_kill | ~a_win);
  assign StallReq   = head_live && (starve_q >= StW'(STARVE_LIMIT));

  always_comb begin
    valid_d  = valid_q;
    kill_d   = kill_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // A is newer than everything already queued; the same-edge push below is not affected.
    if (a_win) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (reg_q[i] == AReg)) kill_d[i] = 1'b1;
      end
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      kill_d[wr_ptr_q]  = 1'b0;
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
    end
  end

  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = WriteRegister;
    write_data_d = WriteData;
    out_is_b_d   = 1'b0;
    if (a_win) begin
      reg_write_d  = 1'b1;
      write_reg_d  = AReg;
      write_data_d = AData;
    end else if (b_load) begin
      reg_write_d  = 1'b1;
      write_reg_d  = reg_q[rd_ptr_q];
      write_data_d = data_q[rd_ptr_q];
      out_is_b_d   = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (b_load || !head_live) begin
      starve_d = '0;
    end else if (a_win && (starve_q < StW'(STARVE_LIMIT))) begin
      starve_d = starve_q + StW'(1);
    end
  end

  always_comb begin
    Pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !kill_q[i]) Pending = Pending | (32'd1 << reg_q[i]);
    end
    if (RegWrite && out_is_b_q) Pending = Pending | (32'd1 << WriteRegister);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q       <= '0;
      kill_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      starve_q      <= '0;
      out_is_b_q    <= 1'b0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      valid_q       <= valid_d;
      kill_q        <= kill_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      starve_q      <= starve_d;
      out_is_b_q    <= out_is_b_d;
      RegWrite      <= reg_write_d;
      WriteRegister <= write_reg_d;
      WriteData     <= write_data_d;
    end
  end

  // Payload storage needs no reset; slot validity is tracked by valid_q.
  always_ff @(posedge Clk) begin
    if (push) begin
      reg_q[wr_ptr_q]  <= BReg;
      data_q[wr_ptr_q] <= BData;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, A path, FIFO fill/drain, kill rules, starvation.
module tb_regfile_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        AValid, BValid, BReady;
  logic [4:0]  AReg, BReg, WriteRegister;
  logic [31:0] AData, BData, WriteData, Pending;
  logic        RegWrite, StallReq;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(
    .DEPTH           (4),
    .STARVE_LIMIT    (8),
    .ZERO_REG_DISCARD(1'b1)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .AValid       (AValid),
    .AReg         (AReg),
    .AData        (AData),
    .BValid       (BValid),
    .BReady       (BReady),
    .BReg         (BReg),
    .BData        (BData),
    .WriteData    (WriteData),
    .WriteRegister(WriteRegister),
    .RegWrite     (RegWrite),
    .Pending      (Pending),
    .StallReq     (StallReq)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, ".regwrite"}, {31'd0, RegWrite}, 32'd0);
    check({tag, ".wdata"}, WriteData, 32'd0);
    check({tag, ".wreg"}, {27'd0, WriteRegister}, 32'd0);
    check({tag, ".pending"}, Pending, 32'd0);
    check({tag, ".stall"}, {31'd0, StallReq}, 32'd0);
    check({tag, ".bready"}, {31'd0, BReady}, 32'd1);
  endtask

  initial begin
    Reset = 1'b1; AValid = 1'b0; AReg = '0; AData = '0;
    BValid = 1'b0; BReg = '0; BData = '0;
    #1;
    check_idle_reset("rst");
    step(); step();
    Reset = 1'b0;
    step();

    // A path
    AValid = 1'b1; AReg = 5'd5; AData = 32'hDEADBEEF;
    step();
    check("a.regwrite", {31'd0, RegWrite}, 32'd1);
    check("a.wreg", {27'd0, WriteRegister}, 32'd5);
    check("a.wdata", WriteData, 32'hDEADBEEF);
    AReg = 5'd0; AData = 32'h12345678;
    step();
    check("a0.regwrite", {31'd0, RegWrite}, 32'd0);
    AValid = 1'b0;
    step();

    // B to r0 is accepted and dropped
    BValid = 1'b1; BReg = 5'd0; BData = 32'h55;
    step();
    BValid = 1'b0;
    check("b0.pending", Pending, 32'd0);
    step();
    check("b0.regwrite", {31'd0, RegWrite}, 32'd0);

    // FIFO fill while A owns the port
    AValid = 1'b1; AReg = 5'd20; AData = 32'hA0;
    for (int i = 1; i <= 4; i++) begin
      BValid = 1'b1; BReg = 5'(i); BData = 32'h100 + 32'(i);
      step();
    end
    check("fill.bready", {31'd0, BReady}, 32'd0);
    check("fill.pending", Pending, 32'h0000_001E);
    BReg = 5'd5; BData = 32'h105;
    step();
    check("full.bready", {31'd0, BReady}, 32'd0);
    check("full.awin", {27'd0, WriteRegister}, 32'd20);
    AValid = 1'b0;
    step();
    check("drain1.wreg", {27'd0, WriteRegister}, 32'd1);
    check("drain1.wdata", WriteData, 32'h101);
    check("drain1.bready", {31'd0, BReady}, 32'd1);
    check("drain1.pending", Pending, 32'h0000_001E);
    step();
    BValid = 1'b0;
    check("drain2.wreg", {27'd0, WriteRegister}, 32'd2);
    check("drain2.pending", Pending, 32'h0000_003C);
    step();
    check("drain3.wreg", {27'd0, WriteRegister}, 32'd3);
    check("drain3.pending", Pending, 32'h0000_0038);
    step();
    check("drain4.wreg", {27'd0, WriteRegister}, 32'd4);
    check("drain4.pending", Pending, 32'h0000_0030);
    step();
    check("drain5.wreg", {27'd0, WriteRegister}, 32'd5);
    check("drain5.wdata", WriteData, 32'h105);
    check("drain5.regwrite", {31'd0, RegWrite}, 32'd1);
    check("drain5.pending", Pending, 32'h0000_0020);
    step();
    check("drained.regwrite", {31'd0, RegWrite}, 32'd0);
    check("drained.pending", Pending, 32'd0);

    // Kill: queued B to r7 overwritten by a later A
    BValid = 1'b1; BReg = 5'd7; BData = 32'h1111;
    step();
    BValid = 1'b0;
    check("kill.pend_set", Pending, 32'h0000_0080);
    AValid = 1'b1; AReg = 5'd7; AData = 32'h2222;
    step();
    AValid = 1'b0;
    check("kill.awrite", WriteData, 32'h2222);
    check("kill.pend_clr", Pending, 32'd0);
    step();
    check("kill.nowrite", {31'd0, RegWrite}, 32'd0);
    step();
    check("kill.nowrite2", {31'd0, RegWrite}, 32'd0);
    check("kill.bready", {31'd0, BReady}, 32'd1);

    // Same edge: B accepted with A to the same register survives
    AValid = 1'b1; AReg = 5'd9; AData = 32'hAAAA;
    BValid = 1'b1; BReg = 5'd9; BData = 32'hBBBB;
    step();
    AValid = 1'b0; BValid = 1'b0;
    check("same.first", WriteData, 32'hAAAA);
    check("same.pending", Pending, 32'h0000_0200);
    step();
    check("same.second", WriteData, 32'hBBBB);
    check("same.wreg", {27'd0, WriteRegister}, 32'd9);
    check("same.regwrite", {31'd0, RegWrite}, 32'd1);
    step();
    check("same.idle", {31'd0, RegWrite}, 32'd0);

    // Starvation
    BValid = 1'b1; BReg = 5'd3; BData = 32'h3333;
    step();
    BValid = 1'b0;
    AValid = 1'b1; AReg = 5'd21; AData = 32'hC0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("starve.%0d", k), {31'd0, StallReq}, (k >= 8) ? 32'd1 : 32'd0);
    end
    step();
    check("starve.sat", {31'd0, StallReq}, 32'd1);
    check("starve.awins", {27'd0, WriteRegister}, 32'd21);
    AValid = 1'b0;
    step();
    check("starve.bwrite", WriteData, 32'h3333);
    check("starve.bwreg", {27'd0, WriteRegister}, 32'd3);
    check("starve.drop", {31'd0, StallReq}, 32'd0);
    step();
    check("starve.after", {31'd0, StallReq}, 32'd0);

    // Reset mid-stream discards queued B
    AValid = 1'b1; AReg = 5'd22; AData = 32'hD0;
    BValid = 1'b1; BReg = 5'd12; BData = 32'hCCCC;
    step();
    BValid = 1'b0;
    check("rst2.pend_set", Pending, 32'h0000_1000);
    #1;
    Reset = 1'b1;
    #1;
    check_idle_reset("rst2");
    step();
    Reset = 1'b0; AValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("rst2.nowrite%0d", k), {31'd0, RegWrite}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
